// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants, PC-select codes, fetch FSM encoding and IF/ID record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_stage_pkg;

    localparam logic [15:0] NOP_INSTR  = 16'h0800;
    localparam logic [15:0] HALT_INSTR = 16'h0000;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_t;

    // IF/ID pipeline record
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        valid;
    } fd_t;

    localparam fd_t FD_BUBBLE = '{instr: NOP_INSTR, pc_inc: 16'h0000, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// Generic pipeline register with flush (load bubble), load and hold.
// Latency: one cycle from i_dat to o_dat.
// Backpressure: i_load low holds contents; i_flush wins over load and hold.
// Ports: clk, rst (sync, active-high), i_load, i_flush, i_dat -> o_dat.
module fd_latch #(
    parameter int           W       = 33,
    parameter logic [W-1:0] NOP_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_flush,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat <= NOP_VAL;
        end else if (i_flush) begin
            r_dat <= NOP_VAL;
        end else if (i_load) begin
            r_dat <= i_dat;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, halt drain FSM and IF/ID register.
// Latency: one cycle imem_instr -> fd_instr; redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; FD_NOP flushes IF/ID; redirect overrides both.
// Ports: clk, rst, PCSrc/br_target/jmp_target (redirect), stall, FD_NOP, imem_instr in;
//        imem_addr (PC), fd_instr/fd_pc_inc/fd_valid (IF/ID), halted out.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] br_target,
    input  logic [15:0] jmp_target,
    input  logic        stall,
    input  logic        FD_NOP,
    input  logic [15:0] imem_instr,
    output logic [15:0] imem_addr,
    output logic [15:0] fd_instr,
    output logic [15:0] fd_pc_inc,
    output logic        fd_valid,
    output logic        halted
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    logic [15:0]  r_pc;
    fetch_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic         r_halted;

    logic [15:0] w_pc_inc;
    logic [15:0] w_target;
    logic        w_redir;
    logic        w_fd_load;
    logic        w_fd_flush;
    fd_t         w_fd_in;
    fd_t         w_fd_q;

    assign w_pc_inc = r_pc + 16'd2;    // wraps FFFE -> 0000
    assign w_target = (PCSrc == PCSRC_JMP) ? jmp_target : br_target;
    // Once halted, only reset restarts the machine; redirects are dropped.
    assign w_redir  = PCSrc[1] && (r_state != ST_HALTED);

    assign w_fd_in = '{instr: imem_instr, pc_inc: w_pc_inc, valid: 1'b1};

    always_comb begin
        w_fd_load  = 1'b0;
        w_fd_flush = 1'b0;
        if (w_redir) begin
            w_fd_flush = 1'b1;
        end else if (r_state != ST_RUN) begin
            w_fd_flush = 1'b1;
        end else if (stall) begin
            w_fd_flush = FD_NOP;
        end else if (FD_NOP) begin
            w_fd_flush = 1'b1;
        end else begin
            w_fd_load  = 1'b1;
        end
    end

    fd_latch #(
        .W       ($bits(fd_t)),
        .NOP_VAL (FD_BUBBLE)
    ) u_fd_latch (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_fd_load),
        .i_flush (w_fd_flush),
        .i_dat   (w_fd_in),
        .o_dat   (w_fd_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else if (w_redir) begin
            // A redirect squashes any HALT still draining: it was younger.
            r_pc    <= w_target;
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!stall) begin
                        r_pc <= w_pc_inc;
                        // Only a HALT that actually lands in IF/ID starts the drain.
                        if (!FD_NOP && (imem_instr == HALT_INSTR)) begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign fd_instr  = w_fd_q.instr;
    assign fd_pc_inc = w_fd_q.pc_inc;
    assign fd_valid  = w_fd_q.valid;
    assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-scenario tasks, expected states queued
// alongside each stimulus step and popped for comparison after the clock edge.
// Instruction memory: 16'h4123 everywhere (mode 0) or 16'h5000|addr[11:0] (mode 1), HALT at halt_addr when enabled.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrc;
    logic [15:0] br_target;
    logic [15:0] jmp_target;
    logic        stall;
    logic        FD_NOP;
    logic [15:0] imem_instr;
    logic [15:0] imem_addr;
    logic [15:0] fd_instr;
    logic [15:0] fd_pc_inc;
    logic        fd_valid;
    logic        halted;

    int          imem_mode = 0;
    logic        halt_en   = 1'b0;
    logic [15:0] halt_addr = 16'h0010;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (halt_en && (imem_addr == halt_addr))
            imem_instr = 16'h0000;
        else if (imem_mode == 0)
            imem_instr = 16'h4123;
        else
            imem_instr = {4'h5, imem_addr[11:0]};
    end

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrc      (PCSrc),
        .br_target  (br_target),
        .jmp_target (jmp_target),
        .stall      (stall),
        .FD_NOP     (FD_NOP),
        .imem_instr (imem_instr),
        .imem_addr  (imem_addr),
        .fd_instr   (fd_instr),
        .fd_pc_inc  (fd_pc_inc),
        .fd_valid   (fd_valid),
        .halted     (halted)
    );

    typedef struct packed {
        logic        r;
        logic [1:0]  src;
        logic [15:0] br;
        logic [15:0] jmp;
        logic        st;
        logic        nop;
    } stim_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] inc;
        logic        vld;
        logic        hlt;
    } exp_t;

    exp_t sb[$];

    function automatic stim_t mk_stim(input logic r, input logic [1:0] src, input logic [15:0] br,
                                      input logic [15:0] jmp, input logic st, input logic nop);
        stim_t s;
        s.r = r; s.src = src; s.br = br; s.jmp = jmp; s.st = st; s.nop = nop;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] pc, input logic [15:0] instr,
                                    input logic [15:0] inc, input logic vld, input logic hlt);
        exp_t e;
        e.pc = pc; e.instr = instr; e.inc = inc; e.vld = vld; e.hlt = hlt;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst        = s.r;
        PCSrc      = s.src;
        br_target  = s.br;
        jmp_target = s.jmp;
        stall      = s.st;
        FD_NOP     = s.nop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, got;
        st[0] = mk_stim(1, 2'b00, 0, 0, 0, 0); ex[0] = mk_exp(16'h0000, NOP, 16'h0000, 0, 0);
        st[1] = mk_stim(1, 2'b00, 0, 0, 0, 0); ex[1] = mk_exp(16'h0000, NOP, 16'h0000, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            st[k+1] = mk_stim(0, 2'b00, 0, 0, 0, 0);
            ex[k+1] = mk_exp(16'(2*k), 16'h4123, 16'(2*k), 1, 0);
        end
        for (int i = 0; i < 6; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL reset step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e, got;
        st[0] = mk_stim(0, 2'b00, 0, 0, 1, 0); ex[0] = mk_exp(16'h0008, 16'h4123, 16'h0008, 1, 0);
        st[1] = mk_stim(0, 2'b00, 0, 0, 1, 0); ex[1] = mk_exp(16'h0008, 16'h4123, 16'h0008, 1, 0);
        st[2] = mk_stim(0, 2'b00, 0, 0, 0, 0); ex[2] = mk_exp(16'h000A, 16'h4123, 16'h000A, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL stall step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
    endtask

    task automatic test_branch_stall();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e, got;
        imem_mode = 1;
        st[0] = mk_stim(0, 2'b10, 16'h0040, 0, 1, 0); ex[0] = mk_exp(16'h0040, NOP, 16'h0000, 0, 0);
        st[1] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[1] = mk_exp(16'h0042, 16'h5040, 16'h0042, 1, 0);
        for (int i = 0; i < 2; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL branch step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e, got;
        st[0] = mk_stim(0, 2'b00, 0, 0, 1, 1); ex[0] = mk_exp(16'h0042, NOP, 16'h0000, 0, 0);
        st[1] = mk_stim(0, 2'b00, 0, 0, 0, 1); ex[1] = mk_exp(16'h0044, NOP, 16'h0000, 0, 0);
        st[2] = mk_stim(0, 2'b00, 0, 0, 0, 0); ex[2] = mk_exp(16'h0046, 16'h5044, 16'h0046, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL flush step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
    endtask

    task automatic test_jump_wrap();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e, got;
        st[0] = mk_stim(0, 2'b11, 0, 16'hFFFE, 0, 0); ex[0] = mk_exp(16'hFFFE, NOP, 16'h0000, 0, 0);
        st[1] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[1] = mk_exp(16'h0000, 16'h5FFE, 16'h0000, 1, 0);
        st[2] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[2] = mk_exp(16'h0002, 16'h5000, 16'h0002, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL jump_wrap step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
    endtask

    // Plain drain (4 edges to halted), ignored redirect, reset, then drain with one stall (5 edges).
    task automatic test_halt_drain();
        stim_t st[16];
        exp_t  ex[16];
        exp_t  e, got;
        halt_en = 1'b1;
        st[0]  = mk_stim(0, 2'b11, 0, 16'h0010, 0, 0); ex[0]  = mk_exp(16'h0010, NOP, 16'h0000, 0, 0);
        st[1]  = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[1]  = mk_exp(16'h0012, 16'h0000, 16'h0012, 1, 0);
        st[2]  = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[2]  = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[3]  = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[3]  = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[4]  = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[4]  = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[5]  = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[5]  = mk_exp(16'h0012, NOP, 16'h0000, 0, 1);
        st[6]  = mk_stim(0, 2'b10, 16'h0020, 0, 0, 0); ex[6]  = mk_exp(16'h0012, NOP, 16'h0000, 0, 1);
        st[7]  = mk_stim(1, 2'b00, 0, 0, 0, 0);        ex[7]  = mk_exp(16'h0000, NOP, 16'h0000, 0, 0);
        st[8]  = mk_stim(0, 2'b11, 0, 16'h0010, 0, 0); ex[8]  = mk_exp(16'h0010, NOP, 16'h0000, 0, 0);
        st[9]  = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[9]  = mk_exp(16'h0012, 16'h0000, 16'h0012, 1, 0);
        st[10] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[10] = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[11] = mk_stim(0, 2'b00, 0, 0, 1, 0);        ex[11] = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[12] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[12] = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[13] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[13] = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[14] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[14] = mk_exp(16'h0012, NOP, 16'h0000, 0, 1);
        st[15] = mk_stim(1, 2'b00, 0, 0, 0, 0);        ex[15] = mk_exp(16'h0000, NOP, 16'h0000, 0, 0);
        for (int i = 0; i < 16; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL halt_drain step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
    endtask

    task automatic test_halt_cancel();
        stim_t st[9];
        exp_t  ex[9];
        exp_t  e, got;
        st[0] = mk_stim(0, 2'b11, 0, 16'h0010, 0, 0); ex[0] = mk_exp(16'h0010, NOP, 16'h0000, 0, 0);
        st[1] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[1] = mk_exp(16'h0012, 16'h0000, 16'h0012, 1, 0);
        st[2] = mk_stim(0, 2'b00, 0, 0, 0, 0);        ex[2] = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        st[3] = mk_stim(0, 2'b10, 16'h0020, 0, 0, 0); ex[3] = mk_exp(16'h0020, NOP, 16'h0000, 0, 0);
        for (int k = 0; k < 5; k++) begin
            st[4+k] = mk_stim(0, 2'b00, 0, 0, 0, 0);
            ex[4+k] = mk_exp(16'(16'h0022 + 2*k), 16'(16'h5020 + 2*k), 16'(16'h0022 + 2*k), 1, 0);
        end
        for (int i = 0; i < 9; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL halt_cancel step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
    endtask

    // HALT at the PC while stalled, then while flushed: neither may start a drain.
    task automatic test_halt_masked();
        stim_t st[7];
        exp_t  ex[7];
        exp_t  e, got;
        st[0] = mk_stim(0, 2'b11, 0, 16'h0010, 0, 0); ex[0] = mk_exp(16'h0010, NOP, 16'h0000, 0, 0);
        st[1] = mk_stim(0, 2'b00, 0, 0, 1, 0);        ex[1] = mk_exp(16'h0010, NOP, 16'h0000, 0, 0);
        st[2] = mk_stim(0, 2'b00, 0, 0, 0, 1);        ex[2] = mk_exp(16'h0012, NOP, 16'h0000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            st[3+k] = mk_stim(0, 2'b00, 0, 0, 0, 0);
            ex[3+k] = mk_exp(16'(16'h0014 + 2*k), 16'(16'h5012 + 2*k), 16'(16'h0014 + 2*k), 1, 0);
        end
        for (int i = 0; i < 7; i++) begin
            apply(st[i]); sb.push_back(ex[i]); tick();
            e = sb.pop_front();
            got = {imem_addr, fd_instr, fd_pc_inc, fd_valid, halted};
            n_checks++;
            if (got !== e)
                $display("FAIL halt_masked step %0d: got pc=%h instr=%h inc=%h vld=%b hlt=%b, want pc=%h instr=%h inc=%h vld=%b hlt=%b",
                         i, got.pc, got.instr, got.inc, got.vld, got.hlt, e.pc, e.instr, e.inc, e.vld, e.hlt);
            else n_pass++;
        end
        halt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_stall();
        test_flush();
        test_jump_wrap();
        test_halt_drain();
        test_halt_cancel();
        test_halt_masked();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
